kennedy_uart_rx: RTL and testbench
==================================

# kennedy_uart_rx

8N1 UART receive path driven by a 16x oversampling tick. It detects the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte with a one-cycle `done` strobe (or `err` on a framing error). It sits behind the board RX pin synchronizer, alongside a `baud_gen` tick source, and feeds the byte-level consumer (FIFO/controller).

## Interface
- `OVERSAMPLE`, default 16: ticks per bit period.
- `DATA_BITS`, default 8: data bits per frame, transmitted LSB first.
- `clk` input 1: system clock; all state is rising-edge.
- `rstN` input 1: asynchronous active-low reset.
- `rx_enabled` input 1: receiver enable; low forces IDLE.
- `in` input 1: serial RX line (idle high), already synchronized.
- `s_tick` input 1: oversample tick, one-`clk` pulse, 16 per bit period.
- `busy` output 1: high while a frame is in progress (START/DATA/STOP).
- `done` output 1: one-`clk` pulse when a valid frame is received.
- `err` output 1: one-`clk` pulse on a framing error (stop bit sampled low).
- `out` output `DATA_BITS`: last valid received byte; held until the next valid frame.

## Operation
- States come from the package enum: IDLE, START, DATA, STOP. The design keeps a 4-bit tick counter, a 3-bit bit counter, and a shift register.
- **IDLE:** if `rx_enabled` and `in`==0, go to START and clear the tick counter. Otherwise stay.
- **START:** count `s_tick`. On the 8th tick (tick count 7, mid start bit):
  - if `in`==0, go to DATA and clear both counters;
  - else treat it as a glitch and return to IDLE with no `done` or `err`.
- **DATA:** on every 16th tick (count 15), shift `in` into the MSB of the shift register (right-shift, LSB-first reception).
  - After bit 7, go to STOP and clear the tick counter.
- **STOP:** on the 16th tick, sample `in`:
  - if 1, load `out` from the shift register, pulse `done`, go to IDLE;
  - if 0, pulse `err`, leave `out` unchanged, go to IDLE.
- **Enable deasserted mid-frame:** `rx_enabled` low in any state aborts to IDLE next cycle. No `done` or `err`; `out` is unchanged.
- **Back-to-back frames:** a start bit immediately after the stop-bit sample is accepted. IDLE re-arms in one cycle.
- The counters advance only on cycles with `s_tick` high. Cycles without a tick hold all state.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `err`=0, `out`=0, all counters 0.
- **Reset mid-frame:** immediate return to IDLE, and `out` is cleared.
- `busy` rises the cycle after the start edge is seen and falls in the same cycle that `done`/`err` rises.
- **Frame latency:** `done` is asserted in the cycle after the `s_tick` that completes the stop-bit mid-sample. That is 8 + 16×8 + 16 = 152 ticks after start detection; with divisor 5 this is 760 clk.
- `done` and the new `out` value appear in the same cycle. `done` and `err` are never high together.
- The minimum inter-frame gap is zero idle ticks.

## Structure
- **Shared package** (`definitions_pkg`): the state enum `rx_state_t` {IDLE, START, DATA, STOP}, the constants `OVERSAMPLE`=16, `DATA_BITS`=8, and the mid-bit constant 7.
- **Sub-module `baud_gen`:** instantiated beside the receiver, not inside it.
  - Ports: `clk`; `reset` (asynchronous active-low, tied to `rstN`); `divisor` (16-bit); `tick`.
  - A free-running counter runs 0..divisor−1, and `tick` pulses for one `clk` when it wraps, giving one tick every `divisor` clocks.
  - A divisor of 0 or 1 gives a tick every cycle. The counter is cleared in reset and `tick` is 0 in reset.
- Bit period = 16 × divisor clocks.

## Test plan
- **Single byte:** divisor 5, 50 ns clock; send 0xA5 (8N1, 80 clk/bit) -> `done` pulse, `out`=0xA5, `busy` low afterwards, `err` never high.
- **Byte stream:** send 0xA5, 0x5A, 0xFF, 0x00, 0x12, 0x34, 0x56, 0x78 with a 2-bit stop gap -> eight `done` pulses, each `out` matching, final `out`=0x78.
- **Glitch rejection:** `in` low for 4 ticks then high -> no DATA entry, no `done`/`err`, `busy` drops within 8 ticks.
- **Framing error:** after 0x3C has been received, send 0x99 with the stop bit 0 -> `err` pulse, no `done`, `out` stays 0x3C.
- **Enable low:** `rx_enabled`=0 while sending 0x55 -> no `busy`, `done` or `err`. Deassert mid-frame -> abort to IDLE.
- **Reset mid-frame:** assert `rstN` low during the DATA bits -> all outputs 0 immediately. After release, the next frame 0x12 is received correctly.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared types and constants for the UART receive path.
package definitions_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_TICK   = 7;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick source: one-clk pulse every `divisor` clocks.
module baud_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] cnt;

    // Divisors of 0 and 1 both collapse to a tick on every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (divisor <= 16'd1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else if (cnt == divisor - 16'd1) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 16'd1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/kennedy_uart_rx.sv
// 8N1 UART receiver on a 16x oversample tick; emits done/err pulses per frame.
// Handshake: done and err are single-cycle, mutually exclusive strobes; out is valid while done is high and held afterwards.
module kennedy_uart_rx #(
    parameter int OVERSAMPLE = definitions_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = definitions_pkg::DATA_BITS
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic                       rx_enabled,
    input  logic                       in,
    input  logic                       s_tick,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [DATA_BITS-1:0]       out,
    output definitions_pkg::rx_state_t state
);

    import definitions_pkg::*;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (!rx_enabled) begin
            state_d = IDLE;
            tick_d  = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!in) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (s_tick) begin
                        if (tick_q == TICK_MID) begin
                            if (!in) begin
                                state_d = DATA;
                                tick_d  = '0;
                                bit_d   = '0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (tick_q == TICK_LAST) begin
                            shift_d = {in, shift_q[DATA_BITS-1:1]};
                            tick_d  = '0;
                            if (bit_q == BIT_LAST) begin
                                state_d = STOP;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (tick_q == TICK_LAST) begin
                            state_d = IDLE;
                            tick_d  = '0;
                            if (in) begin
                                out_d  = shift_q;
                                done_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            tick_d = tick_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign out   = out_q;
    assign state = state_q;

endmodule

// File: tb/tb_kennedy_uart_rx.sv
// Directed bench for kennedy_uart_rx driven by a baud_gen tick at divisor 5.
module tb_kennedy_uart_rx;
  import definitions_pkg::*;

  localparam int BIT_CLK = 80;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        rx_enabled = 1'b0;
  logic        in = 1'b1;
  logic [15:0] divisor = 16'd5;
  logic        s_tick;
  logic        busy, done, err;
  logic [7:0]  out;
  rx_state_t   state;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  model_out = 8'h00;
  int          cyc = 0;
  int          last_done_cyc = 0;
  logic        busy_seen = 1'b0;

  // clock / reset block
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  baud_gen u_baud (
    .clk     (clk),
    .reset   (rstN),
    .divisor (divisor),
    .tick    (s_tick)
  );

  kennedy_uart_rx dut (
    .clk        (clk),
    .rstN       (rstN),
    .rx_enabled (rx_enabled),
    .in         (in),
    .s_tick     (s_tick),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .out        (out),
    .state      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: {err, out} is compared on every done/err strobe
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rstN && (done || err)) begin
      check("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (done) last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got done=%b err=%b out=%h expected no response", done, err, out);
      end else begin
        check("resp", {23'd0, err, out}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic v, input int n_clk);
    in = v;
    repeat (n_clk) @(negedge clk);
  endtask

  // Bad-stop frames hold the line low just past the mid-stop sample and then
  // release it, so the re-armed receiver sees only a rejected glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int gap_bits,
                            input logic expect_resp);
    if (expect_resp) begin
      exp_q.push_back({~stop_ok, stop_ok ? d : model_out});
      if (stop_ok) model_out = d;
    end
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLK);
    if (stop_ok) begin
      send_bit(1'b1, BIT_CLK * (1 + gap_bits));
    end else begin
      send_bit(1'b0, 48);
      send_bit(1'b1, BIT_CLK - 48 + BIT_CLK * gap_bits);
    end
  endtask

  logic [7:0] stream [8];
  int start_cyc;
  int lat;

  initial begin
    stream = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

    // reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_out", {24'd0, out}, 32'd0);
    rstN = 1'b1;
    rx_enabled = 1'b1;
    repeat (20) @(negedge clk);

    // single byte with latency check
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1, 1, 1'b1);
    lat = last_done_cyc - (start_cyc + 1);
    total++;
    if (lat < 755 || lat > 761) begin
      bad++;
      $display("FAIL latency: got %0d clk expected 755..761 clk", lat);
    end
    check("idle_after_a5", {31'd0, busy}, 32'd0);

    // byte stream with 2-bit stop gap
    for (int i = 0; i < 8; i++) send_frame(stream[i], 1'b1, 2, 1'b1);
    check("stream_final_out", {24'd0, out}, 32'h78);

    // back-to-back frames with no idle gap
    send_frame(8'hC3, 1'b1, 0, 1'b1);
    send_frame(8'h81, 1'b1, 1, 1'b1);
    check("b2b_out", {24'd0, out}, 32'h81);

    // glitch: line low for 4 ticks then high
    in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_start", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    in = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy_drop", {31'd0, busy}, 32'd0);
    repeat (BIT_CLK) @(negedge clk);

    // framing error leaves out untouched
    send_frame(8'h3C, 1'b1, 2, 1'b1);
    send_frame(8'h99, 1'b0, 2, 1'b1);
    check("ferr_out_held", {24'd0, out}, 32'h3C);

    // receiver disabled for a whole frame
    rx_enabled = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'h55, 1'b1, 1, 1'b0);
    check("disabled_no_busy", {31'd0, busy_seen}, 32'd0);
    rx_enabled = 1'b1;
    repeat (BIT_CLK) @(negedge clk);

    // enable dropped mid-frame
    send_bit(1'b0, BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    send_bit(1'b0, BIT_CLK);
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rx_enabled = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    send_bit(1'b1, BIT_CLK * 8);
    rx_enabled = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    check("abort_out_held", {24'd0, out}, 32'h3C);

    // reset during data bits
    send_bit(1'b0, BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    send_bit(1'b1, BIT_CLK);
    check("rst_busy_pre", {31'd0, busy}, 32'd1);
    rstN = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    model_out = 8'h00;
    in = 1'b1;
    repeat (5) @(negedge clk);
    rstN = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    send_frame(8'h12, 1'b1, 1, 1'b1);
    check("post_rst_out", {24'd0, out}, 32'h12);

    // final report
    repeat (200) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(50 * 60000);
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
